// File: rtl/cf_fft_1024_8_seq_pkg.sv
// cf_fft_1024_8_seq_pkg: shared state encoding, datapath phase codes and default sizes for the FFT frame sequencer
package cf_fft_1024_8_seq_pkg;
    localparam int DEF_LOG2N  = 10;
    localparam int DEF_PHASES = 6;
    localparam int DEF_DRAIN  = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
    typedef enum logic [2:0] {
        PH_LOAD  = 3'b000,
        PH_MUL   = 3'b010,
        PH_STORE = 3'b100
    } phase_code_e;
endpackage

// File: rtl/cf_fft_1024_8_seq_if.sv
// cf_fft_1024_8_seq_if: host handshake and datapath sequencing bus between the frame sequencer and its users
interface cf_fft_1024_8_seq_if
    import cf_fft_1024_8_seq_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
);
    logic             enable_i;
    logic             start_i;
    logic             abort_i;
    logic             ready_o;
    logic             busy_o;
    logic [2:0]       phase_o;
    logic [3:0]       stage_o;
    logic [LOG2N-2:0] bfly_o;
    logic [LOG2N-1:0] addr_a_o;
    logic [LOG2N-1:0] addr_b_o;
    logic [LOG2N-2:0] twid_o;
    logic             we_o;
    logic             done_o;
    modport master (
        output enable_i, start_i, abort_i,
        input  ready_o, busy_o, phase_o, stage_o, bfly_o, addr_a_o, addr_b_o, twid_o, we_o, done_o
    );
    modport slave (
        input  enable_i, start_i, abort_i,
        output ready_o, busy_o, phase_o, stage_o, bfly_o, addr_a_o, addr_b_o, twid_o, we_o, done_o
    );
endinterface

// File: rtl/cf_fft_1024_8_seq_agen.sv
// cf_fft_1024_8_seq_agen: in-place radix-2 DIT butterfly addresses and twiddle index from stage and butterfly index
module cf_fft_1024_8_seq_agen
    import cf_fft_1024_8_seq_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
) (
    input  logic [3:0]       stage_i,
    input  logic [LOG2N-2:0] bfly_i,
    output logic [LOG2N-1:0] addr_a_o,
    output logic [LOG2N-1:0] addr_b_o,
    output logic [LOG2N-2:0] twid_o
);
    logic [LOG2N-1:0] half, pos, grp;
    always_comb begin
        half     = LOG2N'(1) << stage_i;
        pos      = LOG2N'(bfly_i) & (half - LOG2N'(1));
        grp      = LOG2N'(bfly_i) >> stage_i;
        addr_a_o = (grp << (stage_i + 4'd1)) | pos;
        addr_b_o = addr_a_o | half;
        twid_o   = (LOG2N-1)'(pos << (4'(LOG2N - 1) - stage_i));
    end
endmodule

// File: rtl/cf_fft_1024_8_seq.sv
// cf_fft_1024_8_seq: frame sequencer walking all stages, butterflies and phases of the radix-2 FFT core
module cf_fft_1024_8_seq
    import cf_fft_1024_8_seq_pkg::*;
#(
    parameter int LOG2N  = DEF_LOG2N,
    parameter int PHASES = DEF_PHASES,
    parameter int DRAIN  = DEF_DRAIN
) (
    input logic              clock_c,
    input logic              reset_n_i,
    cf_fft_1024_8_seq_if.slave bus
);
    localparam logic [LOG2N-2:0] K_LAST = '1;
    localparam logic [LOG2N-2:0] K_ONE  = (LOG2N-1)'(1);
    localparam logic [3:0]       S_LAST = 4'(LOG2N - 1);
    localparam logic [2:0]       P_LAST = 3'(PHASES - 1);
    localparam logic [7:0]       D_LAST = 8'(DRAIN - 1);

    state_e           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       s_q, s_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [7:0]       drain_q, drain_d;
    logic [LOG2N-1:0] addr_a, addr_b;
    logic [LOG2N-2:0] twid;
    logic             last_ph, last_k, last_s;

    assign last_ph = phase_q == P_LAST;
    assign last_k  = k_q == K_LAST;
    assign last_s  = s_q == S_LAST;

    always_ff @(posedge clock_c or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            s_q     <= s_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        s_d     = s_q;
        k_d     = k_q;
        drain_d = drain_q;
        if (bus.enable_i) begin
            if (bus.abort_i || state_q == ST_DONE) begin
                state_d = ST_IDLE;
                phase_d = '0;
                s_d     = '0;
                k_d     = '0;
                drain_d = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: state_d = bus.start_i ? ST_RUN : ST_IDLE;
                    ST_RUN: begin
                        if (last_ph && last_k && last_s) begin
                            state_d = ST_DRAIN;
                            drain_d = '0;
                        end else begin
                            phase_d = last_ph ? 3'd0 : phase_q + 3'd1;
                            k_d     = last_ph ? (last_k ? '0 : k_q + K_ONE) : k_q;
                            s_d     = (last_ph && last_k) ? s_q + 4'd1 : s_q;
                        end
                    end
                    ST_DRAIN: begin
                        drain_d = drain_q + 8'd1;
                        state_d = (drain_q == D_LAST) ? ST_DONE : ST_DRAIN;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    cf_fft_1024_8_seq_agen #(.LOG2N(LOG2N)) u_agen (
        .stage_i  (s_q),
        .bfly_i   (k_q),
        .addr_a_o (addr_a),
        .addr_b_o (addr_b),
        .twid_o   (twid)
    );

    assign bus.ready_o  = state_q == ST_IDLE;
    assign bus.busy_o   = state_q == ST_RUN || state_q == ST_DRAIN;
    assign bus.phase_o  = phase_q;
    assign bus.stage_o  = s_q;
    assign bus.bfly_o   = k_q;
    assign bus.addr_a_o = addr_a;
    // counters are zero in IDLE, but the lower leg would still read 1 without this gate
    assign bus.addr_b_o = (state_q == ST_IDLE) ? '0 : addr_b;
    assign bus.twid_o   = twid;
    assign bus.we_o     = state_q == ST_RUN && last_ph;
    assign bus.done_o   = state_q == ST_DONE;
endmodule

// File: tb/tb_cf_fft_1024_8_seq.sv
// tb_cf_fft_1024_8_seq: directed checks of a small (LOG2N=3) and a default-size frame sequencer
module tb_cf_fft_1024_8_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int n, done_n, wecnt, bad, dones, gated, sawdone;

    cf_fft_1024_8_seq_if #(.LOG2N(3)) s_if ();
    cf_fft_1024_8_seq_if d_if ();

    cf_fft_1024_8_seq #(.LOG2N(3), .PHASES(2), .DRAIN(2)) u_small (
        .clock_c   (clk),
        .reset_n_i (rst_n),
        .bus       (s_if.slave)
    );
    cf_fft_1024_8_seq u_dflt (
        .clock_c   (clk),
        .reset_n_i (rst_n),
        .bus       (d_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.enable_i = 1'b1; s_if.start_i = 1'b0; s_if.abort_i = 1'b0;
        d_if.enable_i = 1'b1; d_if.start_i = 1'b0; d_if.abort_i = 1'b0;
        #2;
        chk("rst_ready", s_if.ready_o, 1);
        chk("rst_busy", s_if.busy_o, 0);
        chk("rst_addr_b", s_if.addr_b_o, 0);
        chk("rst_we", s_if.we_o, 0);
        chk("rst_done", s_if.done_o, 0);
        chk("rst_dflt_ready", d_if.ready_o, 1);
        chk("rst_dflt_addr_b", d_if.addr_b_o, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // small frame with a stray start mid-RUN and a start on the DONE cycle
        s_if.start_i = 1'b1; step(); s_if.start_i = 1'b0;
        chk("s_first_ready", s_if.ready_o, 0);
        chk("s_first_busy", s_if.busy_o, 1);
        chk("s_first_phase", s_if.phase_o, 0);
        chk("s_first_addr_a", s_if.addr_a_o, 0);
        chk("s_first_addr_b", s_if.addr_b_o, 1);
        n = 0; done_n = -1; wecnt = 0;
        while (done_n < 0 && n < 100) begin
            if (s_if.done_o) done_n = n;
            else begin
                if (s_if.we_o) wecnt++;
                if (n == 10) begin
                    chk("s1k1_stage", s_if.stage_o, 1);
                    chk("s1k1_bfly", s_if.bfly_o, 1);
                    chk("s1k1_addr_a", s_if.addr_a_o, 1);
                    chk("s1k1_addr_b", s_if.addr_b_o, 3);
                    chk("s1k1_twid", s_if.twid_o, 2);
                end
                if (n == 22) begin
                    chk("s2k3_stage", s_if.stage_o, 2);
                    chk("s2k3_bfly", s_if.bfly_o, 3);
                    chk("s2k3_addr_a", s_if.addr_a_o, 3);
                    chk("s2k3_addr_b", s_if.addr_b_o, 7);
                    chk("s2k3_twid", s_if.twid_o, 3);
                end
                s_if.start_i = (n == 5);
                step(); n++;
            end
        end
        chk("s_done_at", done_n, 26);
        chk("s_we_cnt", wecnt, 12);
        s_if.start_i = 1'b1; step(); s_if.start_i = 1'b0;
        chk("s_after_done_ready", s_if.ready_o, 1);
        chk("s_after_done_done", s_if.done_o, 0);
        step();
        chk("s_done_start_ignored", s_if.busy_o, 0);

        s_if.start_i = 1'b1; s_if.abort_i = 1'b1; step();
        s_if.start_i = 1'b0; s_if.abort_i = 1'b0;
        chk("s_abort_start_ready", s_if.ready_o, 1);
        chk("s_abort_start_busy", s_if.busy_o, 0);

        // abort landing on the edge that would enter DONE
        s_if.start_i = 1'b1; step(); s_if.start_i = 1'b0;
        sawdone = 0;
        for (int i = 0; i < 25; i++) begin
            sawdone |= int'(s_if.done_o);
            step();
        end
        chk("s_pre_abort_busy", s_if.busy_o, 1);
        s_if.abort_i = 1'b1; step(); s_if.abort_i = 1'b0;
        chk("s_abort_done_ready", s_if.ready_o, 1);
        for (int i = 0; i < 10; i++) begin
            sawdone |= int'(s_if.done_o);
            step();
        end
        chk("s_abort_done_suppressed", sawdone, 0);

        // asynchronous reset mid-RUN
        s_if.start_i = 1'b1; step(); s_if.start_i = 1'b0;
        repeat (7) step();
        chk("s_pre_reset_we", s_if.we_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s_midrst_ready", s_if.ready_o, 1);
        chk("s_midrst_busy", s_if.busy_o, 0);
        chk("s_midrst_we", s_if.we_o, 0);
        chk("s_midrst_bfly", s_if.bfly_o, 0);
        chk("s_midrst_phase", s_if.phase_o, 0);
        chk("s_midrst_addr_b", s_if.addr_b_o, 0);
        @(negedge clk) rst_n = 1'b1;
        sawdone = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            sawdone |= int'(s_if.done_o);
        end
        chk("s_no_done_after_rst", sawdone, 0);

        // default size: abort once stage 4 is reached
        d_if.start_i = 1'b1; step(); d_if.start_i = 1'b0;
        chk("d_first_addr_a", d_if.addr_a_o, 0);
        chk("d_first_addr_b", d_if.addr_b_o, 1);
        chk("d_first_busy", d_if.busy_o, 1);
        n = 0;
        while (d_if.stage_o != 4'd4 && n < 20000) begin
            step(); n++;
        end
        chk("d_reach_s4", n, 12288);
        d_if.abort_i = 1'b1; step(); d_if.abort_i = 1'b0;
        chk("d_abort_ready", d_if.ready_o, 1);
        chk("d_abort_busy", d_if.busy_o, 0);
        chk("d_abort_stage", d_if.stage_o, 0);
        chk("d_abort_bfly", d_if.bfly_o, 0);
        chk("d_abort_done", d_if.done_o, 0);

        // full default frame with a 5-cycle enable gap at stage 0, k=100
        d_if.start_i = 1'b1; step(); d_if.start_i = 1'b0;
        n = 0; wecnt = 0; bad = 0; gated = 0;
        while (!d_if.done_o && n < 40000) begin
            if (d_if.busy_o) begin
                if (d_if.we_o) wecnt++;
                if (int'(d_if.addr_b_o) != int'(d_if.addr_a_o) + (1 << d_if.stage_o)) bad++;
            end
            if (gated == 0 && d_if.stage_o == 4'd0 && d_if.bfly_o == 9'd100 && d_if.phase_o == 3'd2) begin
                gated = 1;
                d_if.enable_i = 1'b0;
                repeat (5) begin step(); n++; end
                chk("d_frz_phase", d_if.phase_o, 2);
                chk("d_frz_bfly", d_if.bfly_o, 100);
                chk("d_frz_addr_a", d_if.addr_a_o, 200);
                chk("d_frz_addr_b", d_if.addr_b_o, 201);
                chk("d_frz_twid", d_if.twid_o, 0);
                d_if.enable_i = 1'b1;
            end
            step(); n++;
        end
        chk("d_gap_seen", gated, 1);
        chk("d_done", d_if.done_o, 1);
        chk("d_frame_len", n, 30729);
        chk("d_we_cnt", wecnt, 5120);
        chk("d_addr_pairs_bad", bad, 0);
        dones = 0;
        repeat (10) begin
            step();
            if (d_if.done_o) dones++;
        end
        chk("d_extra_done", dones, 0);
        chk("d_final_ready", d_if.ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cf_fft_1024_8_seq.md
# cf_fft_1024_8_seq

Frame sequencer for the 1024-point, 8-bit radix-2 FFT datapath. On a start request it walks all log2(N) stages and N/2 butterflies per stage, drives the 3-bit phase code that steers the datapath operand muxes, and generates in-place RAM addresses and twiddle indices. It sits between the frame-level host handshake and the cf_fft_1024_8 butterfly/memory core, and is its only source of sequencing.

## Interface
- LOG2N, 10, log2 of transform size N; N/2 butterflies per stage
- PHASES, 6, clocks per butterfly; phase code counts 0..PHASES-1, max 8
- DRAIN, 4, enabled cycles after the last butterfly before done, covering datapath write-back latency

- clock_c  in  1  single clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  global clock enable; low freezes all state and outputs
- start_i  in  1  frame start request; accepted only when ready_o=1
- abort_i  in  1  synchronous abort; returns to IDLE without done_o
- ready_o  out  1  high in IDLE
- busy_o  out  1  high in RUN or DRAIN
- phase_o  out  3  phase code to datapath mux select
- stage_o  out  4  current stage s, 0..LOG2N-1
- bfly_o  out  LOG2N-1  butterfly index k within stage
- addr_a_o  out  LOG2N  upper-leg RAM address
- addr_b_o  out  LOG2N  lower-leg RAM address
- twid_o  out  LOG2N-1  twiddle ROM index
- we_o  out  1  write-back strobe for the current butterfly
- done_o  out  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start_i=1 and enable_i=1. phase, k and s start at 0.
- RUN: phase increments each enabled cycle.
  - At PHASES-1, phase wraps to 0 and k increments.
  - At k=N/2-1 with the phase wrap, k wraps to 0 and s increments.
  - At s=LOG2N-1, k=N/2-1, phase=PHASES-1, the next state is DRAIN.
- DRAIN: counts DRAIN enabled cycles, then goes to DONE. Counters hold at their final values.
- DONE: lasts one enabled cycle with done_o=1, then IDLE. start_i in DONE is ignored.
- Address rules (radix-2 DIT, in place), with half = 1<<s, pos = k & (half-1), grp = k>>s:
  - addr_a = (grp<<(s+1)) | pos
  - addr_b = addr_a | half
  - twid = pos << (LOG2N-1-s)
  - All results are truncated to their port widths.
- we_o = 1 in RUN when phase = PHASES-1; otherwise 0.
- abort_i has priority over every transition. In any state other than IDLE it forces IDLE and clears the counters on the next enabled cycle. done_o is not asserted.
- start_i while busy is ignored. It is not queued.

## Timing
- Reset values: state IDLE, ready_o=1, all other outputs 0.
- All outputs are registered or decoded from registered state. There is no combinational input-to-output path.
- First RUN cycle follows the start-accept edge: phase_o=0, k=0, s=0, addr_a_o=0, addr_b_o=1.
- RUN length is LOG2N·(N/2)·PHASES enabled cycles. The default is 30720.
- done_o rises DRAIN+1 enabled cycles after the last RUN cycle.
- enable_i=0 holds every register, done_o included. A pending done_o persists until the next enabled cycle.
- Reset asserted mid-frame returns immediately to reset values, asynchronously.

## Structure
- Shared package:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - Phase-code constants used by the datapath muxes: 3'b000, 3'b010, 3'b100.
  - Default LOG2N and PHASES.
- One sub-module, cf_fft_1024_8_seq_agen: purely combinational address/twiddle generator from (s, k).
  - It is shared with the verification reference model.
- Counters and FSM stay in the top module.

## Test plan
- Reset and idle: assert reset_n_i low mid-RUN -> all outputs 0 and ready_o=1 at once; no done_o after release.
- Small full frame (LOG2N=3, PHASES=2, DRAIN=2): start pulse -> 24 RUN cycles.
  - Stage 1 k=1 gives addr_a=1, addr_b=3, twid=2.
  - Stage 2 k=3 gives addr_a=3, addr_b=7, twid=3.
  - done_o arrives 3 cycles after the last RUN cycle.
- Default frame: start -> we_o count = 5120, done_o exactly once, every address pair satisfies addr_b = addr_a + (1<<s).
- Enable gating: toggle enable_i low for 5 cycles at k=100 -> phase_o, bfly_o and addresses frozen; total frame length extends by exactly 5 clocks.
- Abort: abort_i at s=4 -> IDLE next cycle, counters 0, no done_o. A new start runs a full frame correctly.
- Simultaneous events:
  - start_i in RUN and in DONE -> ignored.
  - abort_i together with start_i in IDLE -> stays IDLE.
  - abort_i on the DONE cycle -> done_o suppressed.
